// File: rtl/syscall_if.sv
// Syscall bus between the execute stage and the syscall/display unit.
// The CPU side drives the request and register values and receives stall/halt.
interface syscall_if;
   logic        syscall;
   logic [31:0] v0;
   logic [31:0] a0;
   logic        stall;
   logic        halt;

   modport master (
      output syscall, v0, a0,
      input  stall, halt
   );

   modport slave (
      input  syscall, v0, a0,
      output stall, halt
   );
endinterface

// File: rtl/syscall_display.sv
// Syscall service decoder with an 8-digit multiplexed seven-segment driver.
// Halt/pause freeze the CPU; any other service latches a0 for display.
module syscall_display #(
   parameter int unsigned SCAN_DIV   = 16,
   parameter logic [31:0] HALT_CODE  = 32'd10,
   parameter logic [31:0] PAUSE_CODE = 32'd50,
   parameter int unsigned CNT_W      = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   syscall_if.slave    bus,
   input  logic        go,
   output logic [31:0] disp_val,
   output logic [31:0] sys_cnt,
   output logic [7:0]  seg,
   output logic [7:0]  an
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PAUSE = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t               state;
   logic                 stall_q;
   logic                 halt_q;
   logic                 go_q;
   logic                 go_rise;
   logic [CNT_W-1:0]     cnt;
   logic [SCAN_DIV+2:0]  scan;
   logic [2:0]           idx;
   logic [3:0]           nib;

   assign go_rise   = go & ~go_q;
   assign bus.stall = stall_q;
   assign bus.halt  = halt_q;
   assign sys_cnt   = 32'(cnt);

   // Service FSM: decode v0 on each syscall, hold stall until go or reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= RUN;
         stall_q  <= 1'b0;
         halt_q   <= 1'b0;
         go_q     <= 1'b0;
         disp_val <= 32'd0;
         cnt      <= '0;
      end else begin
         go_q <= go;
         unique case (state)
            RUN: begin
               if (bus.syscall) begin
                  cnt <= cnt + 1'b1;
                  if (bus.v0 == HALT_CODE) begin
                     state   <= HALT;
                     stall_q <= 1'b1;
                     halt_q  <= 1'b1;
                  end else if (bus.v0 == PAUSE_CODE) begin
                     state   <= PAUSE;
                     stall_q <= 1'b1;
                  end else begin
                     disp_val <= bus.a0;
                  end
               end
            end
            PAUSE: begin
               if (go_rise) begin
                  state   <= RUN;
                  stall_q <= 1'b0;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state   <= RUN;
               stall_q <= 1'b0;
               halt_q  <= 1'b0;
            end
         endcase
      end
   end

   // Free-running scan counter; top three bits select the lit digit.
   always_ff @(posedge clk) begin
      if (!rst_n) scan <= '0;
      else        scan <= scan + 1'b1;
   end

   assign idx = scan[SCAN_DIV+2:SCAN_DIV];
   assign nib = disp_val[{idx, 2'b00} +: 4];
   assign an  = ~(8'h01 << idx);

   // Hex digit to active-low segment pattern, decimal point off.
   always_comb begin
      seg = 8'hFF;
      case (nib)
         4'h0: seg = 8'hC0;
         4'h1: seg = 8'hF9;
         4'h2: seg = 8'hA4;
         4'h3: seg = 8'hB0;
         4'h4: seg = 8'h99;
         4'h5: seg = 8'h92;
         4'h6: seg = 8'h82;
         4'h7: seg = 8'hF8;
         4'h8: seg = 8'h80;
         4'h9: seg = 8'h90;
         4'hA: seg = 8'h88;
         4'hB: seg = 8'h83;
         4'hC: seg = 8'hC6;
         4'hD: seg = 8'hA1;
         4'hE: seg = 8'h86;
         4'hF: seg = 8'h8E;
         default: seg = 8'hFF;
      endcase
   end

endmodule

// File: tb/tb_syscall_display.sv
// Scoreboard bench for syscall_display: a behavioural model queues the
// expected post-edge outputs per cycle, which are popped and compared.
module tb_syscall_display;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b0;
   logic [31:0] disp_val, sys_cnt;
   logic [7:0]  seg, an;
   logic [31:0] disp_w, cnt_w;
   logic [7:0]  seg_w, an_w;

   int n_chk = 0;
   int n_err = 0;

   syscall_if bus ();
   syscall_if bus_w ();

   syscall_display #(.SCAN_DIV(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .go(go),
      .disp_val(disp_val), .sys_cnt(sys_cnt), .seg(seg), .an(an)
   );

   syscall_display #(.SCAN_DIV(2), .CNT_W(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .bus(bus_w), .go(go),
      .disp_val(disp_w), .sys_cnt(cnt_w), .seg(seg_w), .an(an_w)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        halt;
      logic [31:0] disp;
      logic [31:0] cnt;
      logic [7:0]  an;
      logic [7:0]  seg;
   } exp_t;

   exp_t q[$];

   logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
      8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1,
      8'h86, 8'h8E};

   // model state: 0 run, 1 pause, 2 halt
   int          m_st = 0;
   logic        m_goq = 1'b0;
   logic [31:0] m_disp = 0;
   logic [31:0] m_cnt = 0;
   logic [4:0]  m_scan = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic r, input logic sc,
                        input logic [31:0] v, input logic [31:0] a,
                        input logic g);
      exp_t e;
      logic rise;
      int   ix;
      if (!r) begin
         m_st = 0; m_goq = 0; m_disp = 0; m_cnt = 0; m_scan = 0;
      end else begin
         rise = g & ~m_goq;
         m_goq = g;
         m_scan = m_scan + 5'd1;
         if (m_st == 0) begin
            if (sc) begin
               m_cnt = m_cnt + 1;
               if (v == 32'd10)      m_st = 2;
               else if (v == 32'd50) m_st = 1;
               else                  m_disp = a;
            end
         end else if (m_st == 1) begin
            if (rise) m_st = 0;
         end
      end
      ix = int'(m_scan[4:2]);
      e.stall = (m_st != 0);
      e.halt  = (m_st == 2);
      e.disp  = m_disp;
      e.cnt   = m_cnt;
      e.an    = ~(8'h01 << ix);
      e.seg   = tbl[(m_disp >> (4 * ix)) & 32'hF];
      q.push_back(e);
   endtask

   task automatic cyc(input logic r, input logic sc,
                      input logic [31:0] v, input logic [31:0] a,
                      input logic g);
      exp_t e;
      rst_n = r;
      bus.syscall = sc;
      bus.v0 = v;
      bus.a0 = a;
      go = g;
      model(r, sc, v, a, g);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         chk("sbq", 32'd0, 32'd1);
      end else begin
         e = q.pop_front();
         chk("stall", 32'(bus.stall), 32'(e.stall));
         chk("halt", 32'(bus.halt), 32'(e.halt));
         chk("disp", disp_val, e.disp);
         chk("cnt", sys_cnt, e.cnt);
         chk("an", 32'(an), 32'(e.an));
         chk("seg", 32'(seg), 32'(e.seg));
      end
   endtask

   task automatic idle(input int n, input logic g);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'd0, 32'd0, g);
   endtask

   initial begin
      bus.syscall = 0; bus.v0 = 0; bus.a0 = 0;
      bus_w.syscall = 0; bus_w.v0 = 0; bus_w.a0 = 0;

      // reset with a halt syscall present
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'd10, 32'd7, 1'b0);
      chk("rst_an", 32'(an), 32'h0000_00FE);
      chk("rst_seg", 32'(seg), 32'h0000_00C0);
      idle(4, 1'b0);
      chk("an_d1", 32'(an), 32'h0000_00FD);

      // print service and full display sweep
      cyc(1'b1, 1'b1, 32'd1, 32'h1234ABCD, 1'b0);
      chk("p_disp", disp_val, 32'h1234ABCD);
      chk("p_cnt", sys_cnt, 32'd1);
      for (int i = 0; i < 32; i++) begin
         idle(1, 1'b0);
         if (an == 8'hFE) chk("d0", 32'(seg), 32'h0000_00A1);
         if (an == 8'hEF) chk("d4", 32'(seg), 32'h0000_0099);
         if (an == 8'h7F) chk("d7", 32'(seg), 32'h0000_00F9);
      end

      // pause with go already held; syscalls while paused ignored
      idle(2, 1'b1);
      cyc(1'b1, 1'b1, 32'd50, 32'h5555_5555, 1'b1);
      chk("pa_stall", 32'(bus.stall), 32'd1);
      idle(3, 1'b1);
      cyc(1'b1, 1'b1, 32'd1, 32'hDEAD_BEEF, 1'b1);
      idle(1, 1'b0);
      chk("pa_hold", 32'(bus.stall), 32'd1);
      idle(1, 1'b1);
      chk("pa_rel", 32'(bus.stall), 32'd0);
      chk("pa_cnt", sys_cnt, 32'd2);

      // simultaneous syscall and go rise in run
      idle(1, 1'b0);
      cyc(1'b1, 1'b1, 32'd3, 32'h0BAD_F00D, 1'b1);
      idle(2, 1'b0);
      cyc(1'b1, 1'b1, 32'd50, 32'd0, 1'b1);
      cyc(1'b1, 1'b1, 32'd9, 32'h0000_0F0F, 1'b0);
      idle(1, 1'b1);
      idle(1, 1'b0);

      // halt is absorbing until reset
      cyc(1'b1, 1'b1, 32'd10, 32'h1111_1111, 1'b0);
      chk("h_halt", 32'(bus.halt), 32'd1);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b1, 32'd1, 32'(i + 40), 1'(i % 2));
         cyc(1'b1, 1'b1, 32'd50, 32'd0, 1'b0);
      end
      cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("h_rst", sys_cnt, 32'd0);
      idle(2, 1'b0);

      // reset during pause with go high
      cyc(1'b1, 1'b1, 32'd50, 32'd0, 1'b0);
      idle(2, 1'b0);
      cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      chk("rp_stall", 32'(bus.stall), 32'd0);
      idle(3, 1'b1);
      cyc(1'b1, 1'b1, 32'd50, 32'd0, 1'b1);
      idle(2, 1'b1);
      chk("rp_hold", 32'(bus.stall), 32'd1);
      idle(1, 1'b0);
      idle(1, 1'b1);
      cyc(1'b1, 1'b1, 32'd2, 32'h0000_CAFE, 1'b1);

      // narrow counter build wraps back to zero
      for (int i = 0; i < 16; i++) begin
         bus_w.syscall = 1'b1;
         bus_w.v0 = 32'd1;
         bus_w.a0 = 32'(i + 100);
         idle(1, 1'b0);
         chk("w_cnt", cnt_w, 32'((i + 1) % 16));
      end
      bus_w.syscall = 1'b0;
      chk("w_disp", disp_w, 32'd115);
      idle(2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/syscall_display.md
Name: syscall_display

Overview:
- Downstream consumer of the register file's dedicated v0 ($2) and a0 ($4) read ports.
- On each executed syscall, decodes the service code in v0:
  - halt service: stops the CPU permanently;
  - pause service: stalls the CPU until the operator presses go;
  - any other code: latches a0 for output.
- Drives the board's 8-digit multiplexed seven-segment display with the latched value and counts syscalls.

Parameters:
- SCAN_DIV, 16, log2 of cycles each digit stays lit; scan counter width is SCAN_DIV+3.
- HALT_CODE, 10, v0 value that halts the CPU.
- PAUSE_CODE, 50, v0 value that pauses the CPU until go.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- syscall  in  1  high for one cycle while a syscall instruction is in execute.
- v0  in  32  register $2 value from register file.
- a0  in  32  register $4 value from register file.
- go  in  1  debounced continue button, level, active high.
- stall  out  1  1 = freeze PC and pipeline.
- halt  out  1  1 = program finished.
- disp_val  out  32  last latched a0.
- sys_cnt  out  32  number of syscalls accepted in RUN.
- seg  out  8  active-low segments; bit7 = dp, bits6:0 = g,f,e,d,c,b,a.
- an  out  8  active-low digit enables; an[0] = rightmost digit = disp_val[3:0].

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=RUN, disp_val=0, sys_cnt=0, scan counter=0, go_q=0.
  - Resulting outputs: stall=0, halt=0, an=8'hFE, seg=8'hC0.
  - Reset overrides every other event in the same cycle, including mid-PAUSE and HALT.
- Register-file timing:
  - Register-file writes occur on negedge, so v0/a0 are stable at the posedge where syscall is sampled.
  - v0/a0 are sampled only when syscall=1 in RUN.
- State machine (Moore outputs: stall = state!=RUN, halt = state==HALT):
  - RUN:
    - syscall & v0==HALT_CODE -> HALT.
    - syscall & v0==PAUSE_CODE -> PAUSE.
    - syscall otherwise -> disp_val<=a0, stay RUN.
    - Every syscall in RUN increments sys_cnt, all three cases included; 32-bit wrap from FFFFFFFF to 0.
  - PAUSE: go_rise -> RUN; otherwise stay. The syscall input is ignored.
  - HALT: absorbing; only reset exits. syscall and go are ignored.
- Stall latency:
  - Syscall sampled at edge N -> stall high immediately after edge N.
  - The syscall instruction itself completes at edge N; no further instruction advances.
- go handling:
  - go_q<=go every cycle in all states; go_rise = go & ~go_q.
  - go held high while entering PAUSE does not release; a fresh 0->1 transition is required.
  - go_rise in RUN or HALT has no effect.
  - PAUSE exit: go_rise at edge M -> stall low after edge M.
- Display scan:
  - Free-running counter increments every cycle, wraps at 2^(SCAN_DIV+3), runs in all states.
  - idx = counter[SCAN_DIV+2:SCAN_DIV].
  - an = ~(8'h01<<idx).
  - seg = decode(disp_val[4*idx+3:4*idx]) with bit7=1 (dp off).
  - seg/an are combinational from registers, with no glitch on a disp_val change beyond one cycle.
- Decode table (hex digit -> seg), 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Simultaneous syscall and go_rise in RUN: the syscall is processed and go is ignored.

Test Plan (SCAN_DIV=2 unless noted):
- Reset: hold rst_n=0 with syscall=1, v0=10 for 3 cycles -> stall=0, halt=0, sys_cnt=0, disp_val=0, an=FE, seg=C0. Release, then idle 4 cycles -> an=FD.
- Print: syscall pulse with v0=1, a0=32'h1234ABCD -> disp_val=1234ABCD, sys_cnt=1, stall stays 0. Sweep 32 cycles -> digit0 seg=A1 (d), digit4 seg=99 (4), digit7 seg=F9 (1).
- Pause: syscall with v0=50 -> stall=1 next cycle, disp_val unchanged. Hold go=1 before entry -> still stalled. Drop go, then raise go -> stall=0 after that edge, sys_cnt incremented by 1.
- Halt: syscall with v0=10 -> halt=1, stall=1. Further syscall pulses and go pulses -> no change to sys_cnt or disp_val. Pulse rst_n=0 -> RUN, all counters 0.
- Counter wrap: preload via 2^32-1 syscalls (forced or small-width build) -> next syscall gives sys_cnt=0.
- Reset mid-PAUSE: enter PAUSE, assert rst_n=0 for one cycle with go=1 -> stall=0 after reset; go_q=0, so go still high yields no spurious effect in RUN.
